// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch predictor for the 5-stage RV32I pipeline. A direct-mapped
//   BTB supplies the target and, in MODE 0, a 1-bit direction per entry. In
//   MODE 1 the direction comes from a separate table of 2-bit saturating
//   counters (BHT). Lookup is combinational on pc_if. Training arrives from EX
//   and takes effect on the next rising edge, with no bypass into the lookup.
//
// Ports
//   clk              core clock
//   rst              synchronous reset, active low
//   pc_if            fetch PC to look up
//   pred_taken       predicted direction for pc_if
//   pred_target      predicted target (pc_if+4 on a BTB miss)
//   upd_valid        EX holds a resolved conditional branch
//   upd_pc           PC of the resolved branch
//   upd_taken        actual outcome
//   upd_target       actual target
//   upd_pred_taken   direction that was predicted in IF
//   upd_pred_target  target that was predicted in IF
//   mispredict       combinational misprediction flag for the EX branch
//   clear_stats      zero both statistics counters
//   br_count         resolved branches (saturating)
//   miss_count       mispredicted branches (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int BTB_IDX_W = 6,
    parameter int BHT_IDX_W = 12,
    parameter int MODE      = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_if,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == 2'b00) ? v : v - 2'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Valid and state1 are control and are reset; tag/target are data and
    // only ever become meaningful together with a valid write.
    logic             btb_valid  [BTB_N];
    logic             btb_state  [BTB_N];
    logic [TAG_W-1:0] btb_tag    [BTB_N];
    logic [31:0]      btb_target [BTB_N];

    logic [BTB_IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]     lk_tag, up_tag;
    logic                 lk_hit, up_hit, lk_dir;

    assign lk_idx = pc_if[BTB_IDX_W+1:2];
    assign lk_tag = pc_if[31:BTB_IDX_W+2];
    assign up_idx = upd_pc[BTB_IDX_W+1:2];
    assign up_tag = upd_pc[31:BTB_IDX_W+2];

    assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    assign pred_taken  = lk_hit && lk_dir;
    assign pred_target = lk_hit ? btb_target[lk_idx] : pc_if + 32'd4;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    // Instruction-alignment bits never take part in indexing; state1 is only
    // consulted in MODE 0.
    logic unused_sink;
    assign unused_sink = ^{pc_if[1:0], upd_pc[1:0], btb_state[lk_idx]};

    // Update stage: BTB control bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid[i] <= 1'b0;
                btb_state[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                btb_valid[up_idx] <= 1'b1;
                btb_state[up_idx] <= 1'b1;
            end else if (up_hit) begin
                btb_state[up_idx] <= 1'b0;
            end
        end
    end

    // Update stage: BTB data; taken branches allocate or replace outright
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[up_idx]    <= up_tag;
            btb_target[up_idx] <= upd_target;
        end
    end

    generate
        if (MODE == 1) begin : g_bht
            localparam int BHT_N = 1 << BHT_IDX_W;
            logic [1:0]           bht [BHT_N];
            logic [BHT_IDX_W-1:0] bht_lk_idx, bht_up_idx;

            assign bht_lk_idx = pc_if[BHT_IDX_W+1:2];
            assign bht_up_idx = upd_pc[BHT_IDX_W+1:2];
            assign lk_dir     = bht[bht_lk_idx][1];

            // Update stage: direction counters, reset to weakly not-taken
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < BHT_N; i++) begin
                        bht[i] <= 2'b01;
                    end
                end else if (upd_valid) begin
                    bht[bht_up_idx] <= upd_taken ? sat_inc2(bht[bht_up_idx])
                                                 : sat_dec2(bht[bht_up_idx]);
                end
            end
        end else begin : g_state1
            assign lk_dir = btb_state[lk_idx];
        end
    endgenerate

    // Update stage: statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst || clear_stats) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (upd_valid) br_count <= sat_inc_cnt(br_count);
            if (mispredict) miss_count <= sat_inc_cnt(miss_count);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int BTB_IDX_W = 6;
    localparam int BHT_IDX_W = 12;
    localparam int CNT_W     = 8;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [31:0]      pc_if = 32'h0;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             upd_valid = 1'b0;
    logic [31:0]      upd_pc = 32'h0;
    logic             upd_taken = 1'b0;
    logic [31:0]      upd_target = 32'h0;
    logic             upd_pred_taken = 1'b0;
    logic [31:0]      upd_pred_target = 32'h0;
    logic             mispredict;
    logic             clear_stats = 1'b0;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_predictor #(
        .BTB_IDX_W(BTB_IDX_W), .BHT_IDX_W(BHT_IDX_W), .MODE(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .clear_stats(clear_stats), .br_count(br_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Each BTB slot remembers the full PC of the branch that owns it.
    logic [31:0] m_pc  [int];
    logic [31:0] m_tgt [int];
    int          m_ctr [int];
    longint      m_br, m_miss;

    function automatic int btb_slot(input logic [31:0] pc);
        return int'(pc / 4) % (1 << BTB_IDX_W);
    endfunction

    function automatic int bht_slot(input logic [31:0] pc);
        return int'(pc / 4) % (1 << BHT_IDX_W);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s = btb_slot(pc);
        if (!m_pc.exists(s)) return 1'b0;
        return (m_pc[s] / (1 << (BTB_IDX_W + 2))) == (pc / (1 << (BTB_IDX_W + 2)));
    endfunction

    function automatic int ctr_of(input logic [31:0] pc);
        int s = bht_slot(pc);
        return m_ctr.exists(s) ? m_ctr[s] : 1;
    endfunction

    function automatic bit exp_taken(input logic [31:0] pc);
        return m_hit(pc) && (ctr_of(pc) >= 2);
    endfunction

    function automatic logic [31:0] exp_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[btb_slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit exp_misp();
        if (!upd_valid) return 1'b0;
        if (upd_pred_taken != upd_taken) return 1'b1;
        return upd_taken && (upd_pred_target != upd_target);
    endfunction

    // Advance one clock, applying the same edge to the model. Ends on negedge.
    task automatic tick();
        bit mp;
        int c;
        mp = exp_misp();
        @(posedge clk);
        if (!rst) begin
            m_pc.delete();
            m_tgt.delete();
            m_ctr.delete();
            m_br   = 0;
            m_miss = 0;
        end else begin
            if (upd_valid) begin
                c = ctr_of(upd_pc);
                if (upd_taken) begin
                    m_pc[btb_slot(upd_pc)]  = upd_pc;
                    m_tgt[btb_slot(upd_pc)] = upd_target;
                    m_ctr[bht_slot(upd_pc)] = (c < 3) ? c + 1 : 3;
                end else begin
                    m_ctr[bht_slot(upd_pc)] = (c > 0) ? c - 1 : 0;
                end
            end
            if (clear_stats) begin
                m_br   = 0;
                m_miss = 0;
            end else begin
                if (upd_valid && m_br < CNT_MAX) m_br++;
                if (mp && m_miss < CNT_MAX) m_miss++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_valid = v; upd_pc = pc; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    task automatic idle();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        clear_stats = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        pc_if = 32'h100;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target got %h want 00000104", pred_target); end
        n_cmp++; if (br_count !== '0) begin n_fail++; $display("FAIL reset_br_count got %0d want 0", br_count); end
        n_cmp++; if (miss_count !== '0) begin n_fail++; $display("FAIL reset_miss_count got %0d want 0", miss_count); end
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict got %0b want 0", mispredict); end
    endtask

    task automatic test_bht_train();
        set_upd(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        pc_if = 32'h100;
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL train_mispredict got %0b want 1", mispredict); end
        // Same-cycle lookup must still see the pre-update table.
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL no_bypass_taken got %0b want 0", pred_taken); end
        tick();
        idle();
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_pred_taken got %0b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h40) begin n_fail++; $display("FAIL train_pred_target got %h want 00000040", pred_target); end
        n_cmp++; if (br_count !== 8'd1) begin n_fail++; $display("FAIL train_br_count got %0d want 1", br_count); end
        n_cmp++; if (miss_count !== 8'd1) begin n_fail++; $display("FAIL train_miss_count got %0d want 1", miss_count); end
    endtask

    task automatic test_bht_hysteresis();
        // Two more taken: counter reaches 11.
        for (int i = 0; i < 2; i++) begin
            set_upd(1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
            tick();
        end
        set_upd(1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        tick();
        idle();
        pc_if = 32'h100;
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL hyst_one_nt_taken got %0b want 1", pred_taken); end
        set_upd(1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        tick();
        idle();
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL hyst_two_nt_taken got %0b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h40) begin n_fail++; $display("FAIL hyst_target_kept got %h want 00000040", pred_target); end
        n_cmp++; if (br_count !== 8'd5) begin n_fail++; $display("FAIL hyst_br_count got %0d want 5", br_count); end
        n_cmp++; if (miss_count !== 8'd3) begin n_fail++; $display("FAIL hyst_miss_count got %0d want 3", miss_count); end
    endtask

    task automatic test_alias();
        logic [31:0] alias_pc;
        alias_pc = 32'h100 + (32'd4 << BTB_IDX_W);
        do_reset();
        set_upd(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
        tick();
        set_upd(1'b1, alias_pc, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        idle();
        pc_if = 32'h100;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_old_taken got %0b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL alias_old_target got %h want 00000104", pred_target); end
        pc_if = alias_pc;
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_new_taken got %0b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h80) begin n_fail++; $display("FAIL alias_new_target got %h want 00000080", pred_target); end
    endtask

    task automatic test_not_taken_no_alloc();
        do_reset();
        set_upd(1'b1, 32'h500, 1'b0, 32'h700, 1'b0, 32'h0);
        tick();
        idle();
        pc_if = 32'h500;
        #1;
        n_cmp++; if (pred_target !== 32'h504) begin n_fail++; $display("FAIL nt_alloc_target got %h want 00000504", pred_target); end
        // Counter now 00; one taken allocates the entry but only reaches 01.
        set_upd(1'b1, 32'h500, 1'b1, 32'h700, 1'b0, 32'h0);
        tick();
        idle();
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_weak_taken got %0b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h700) begin n_fail++; $display("FAIL nt_hit_target got %h want 00000700", pred_target); end
    endtask

    task automatic test_mispredict_stats();
        do_reset();
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL mp_target_mispredict got %0b want 1", mispredict); end
        tick();
        n_cmp++; if (br_count !== 8'd1) begin n_fail++; $display("FAIL mp_br_count got %0d want 1", br_count); end
        n_cmp++; if (miss_count !== 8'd1) begin n_fail++; $display("FAIL mp_miss_count got %0d want 1", miss_count); end
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL mp_correct got %0b want 0", mispredict); end
        set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h40);
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL mp_nt_target_ignored got %0b want 0", mispredict); end
        set_upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h40);
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL mp_invalid got %0b want 0", mispredict); end
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
        clear_stats = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++; if (br_count !== '0) begin n_fail++; $display("FAIL clear_br_count got %0d want 0", br_count); end
        n_cmp++; if (miss_count !== '0) begin n_fail++; $display("FAIL clear_miss_count got %0d want 0", miss_count); end
    endtask

    task automatic test_reset_inflight();
        set_upd(1'b1, 32'h300, 1'b1, 32'h40, 1'b0, 32'h0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        pc_if = 32'h300;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_taken got %0b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h304) begin n_fail++; $display("FAIL rst_inflight_target got %h want 00000304", pred_target); end
        n_cmp++; if (br_count !== '0) begin n_fail++; $display("FAIL rst_inflight_br got %0d want 0", br_count); end
        n_cmp++; if (miss_count !== '0) begin n_fail++; $display("FAIL rst_inflight_miss got %0d want 0", miss_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < int'(CNT_MAX) + 5; i++) begin
            set_upd(1'b1, 32'h900, 1'b1, 32'h40, 1'b0, 32'h0);
            tick();
        end
        set_upd(1'b1, 32'h900, 1'b1, 32'h40, 1'b1, 32'h40);
        tick();
        idle();
        #1;
        n_cmp++; if (br_count !== 8'hFF) begin n_fail++; $display("FAIL sat_br_count got %0d want 255", br_count); end
        n_cmp++; if (miss_count !== 8'hFF) begin n_fail++; $display("FAIL sat_miss_count got %0d want 255", miss_count); end
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 2)) * 256
               + 32'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [31:0] p;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            clear_stats = ($urandom_range(0, 39) == 0);
            p = rand_pc();
            upd_valid  = ($urandom_range(0, 3) != 0);
            upd_pc     = p;
            upd_taken  = 1'($urandom_range(0, 1));
            upd_target = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
            if ($urandom_range(0, 1) == 1) begin
                upd_pred_taken  = exp_taken(p);
                upd_pred_target = exp_target(p);
            end else begin
                upd_pred_taken  = 1'($urandom_range(0, 1));
                upd_pred_target = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
            end
            pc_if = rand_pc();
            #1;
            n_cmp++; if (pred_taken !== exp_taken(pc_if)) begin n_fail++; $display("FAIL rand_pred_taken cyc %0d pc %h got %0b want %0b", i, pc_if, pred_taken, exp_taken(pc_if)); end
            n_cmp++; if (pred_target !== exp_target(pc_if)) begin n_fail++; $display("FAIL rand_pred_target cyc %0d pc %h got %h want %h", i, pc_if, pred_target, exp_target(pc_if)); end
            n_cmp++; if (mispredict !== exp_misp()) begin n_fail++; $display("FAIL rand_mispredict cyc %0d got %0b want %0b", i, mispredict, exp_misp()); end
            n_cmp++; if (longint'(br_count) != m_br) begin n_fail++; $display("FAIL rand_br_count cyc %0d got %0d want %0d", i, br_count, m_br); end
            n_cmp++; if (longint'(miss_count) != m_miss) begin n_fail++; $display("FAIL rand_miss_count cyc %0d got %0d want %0d", i, miss_count, m_miss); end
            tick();
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_bht_train();
        test_bht_hysteresis();
        test_alias();
        test_not_taken_no_alloc();
        test_mispredict_stats();
        test_reset_inflight();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
